// File: rtl/grid_pkg.sv
// Shared definitions for the grid streamer: FSM state codes and default grid size.
// No logic; constants and types only.
// Imported by grid_streamer and available to any sibling block.
package grid_pkg;

    localparam int GRID_WIDTH  = 8;
    localparam int GRID_HEIGHT = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_RUN   = 2'd2;
    localparam state_t ST_DRAIN = 2'd3;

endpackage

// File: rtl/cell_grid.sv
// Purpose: one Game-of-Life generation over a flattened WIDTH x HEIGHT grid, dead border.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the input grid continuously.
module cell_grid #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8
) (
    input  logic [WIDTH*HEIGHT-1:0] cur_state,
    output logic [WIDTH*HEIGHT-1:0] next_state
);

    // Grid surrounded by a one-cell ring of zeros so every cell sees eight
    // neighbours with constant indices and nothing wraps across an edge.
    // pad[r+1] holds grid row r; bit b+1 of a padded row holds row bit b.
    logic [HEIGHT+1:0][WIDTH+1:0] pad;

    assign pad[0]        = '0;
    assign pad[HEIGHT+1] = '0;

    for (genvar r = 0; r < HEIGHT; r++) begin : g_pad
        assign pad[r+1] = {1'b0, cur_state[(HEIGHT-1-r)*WIDTH +: WIDTH], 1'b0};
    end

    for (genvar r = 0; r < HEIGHT; r++) begin : g_row
        for (genvar b = 0; b < WIDTH; b++) begin : g_cell
            logic [3:0] nbr;
            logic       self_alive;

            assign self_alive = pad[r+1][b+1];
            assign nbr = 4'(pad[r][b])   + 4'(pad[r][b+1])   + 4'(pad[r][b+2])
                       + 4'(pad[r+1][b])                     + 4'(pad[r+1][b+2])
                       + 4'(pad[r+2][b]) + 4'(pad[r+2][b+1]) + 4'(pad[r+2][b+2]);

            // Birth on exactly three neighbours, survival on two or three.
            assign next_state[(HEIGHT-1-r)*WIDTH + b] = (nbr == 4'd3) || (self_alive && (nbr == 4'd2));
        end
    end

endmodule

// File: rtl/grid_streamer.sv
// Purpose: load a grid row by row, run step_count Life generations, stream the rows back.
// Latency: first out_valid K+1 cycles after the last load handshake (K = step_count).
// Backpressure: rows held stable until out_ready; load_valid gaps simply stall loading.
module grid_streamer
    import grid_pkg::*;
#(
    parameter int WIDTH  = GRID_WIDTH,
    parameter int HEIGHT = GRID_HEIGHT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       step_count,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    // Row counter is one bit wider than the row index; it never passes HEIGHT-1
    // because it is cleared on the last handshake of each phase.
    localparam int               ROW_W    = $clog2(HEIGHT) + 1;
    localparam int               IDX_W    = ROW_W - 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

    state_t                       state_q;
    logic [ROW_W-1:0]             row_cnt_q;
    logic [7:0]                   gen_cnt_q;
    logic                         done_q;
    // Index 0 is the most significant row, so the packed array is already in
    // the flattened top-row-first order expected by cell_grid.
    logic [0:HEIGHT-1][WIDTH-1:0] grid_q;
    logic [WIDTH*HEIGHT-1:0]      grid_next;
    logic [IDX_W-1:0]             row_idx;
    logic                         load_fire;
    logic                         out_fire;

    assign row_idx    = row_cnt_q[IDX_W-1:0];
    assign load_ready = (state_q == ST_LOAD);
    assign out_valid  = (state_q == ST_DRAIN);
    assign out_data   = grid_q[row_idx];
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign load_fire  = load_valid && load_ready;
    assign out_fire   = out_valid && out_ready;

    cell_grid #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_cell_grid (
        .cur_state  (grid_q),
        .next_state (grid_next)
    );

    // Sequencer: IDLE -> LOAD -> (RUN) -> DRAIN -> IDLE, with a one-cycle done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            row_cnt_q <= '0;
            gen_cnt_q <= '0;
            done_q    <= 1'b0;
            grid_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        gen_cnt_q <= step_count;
                        row_cnt_q <= '0;
                        state_q   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (load_fire) begin
                        grid_q[row_idx] <= load_data;
                        if (row_cnt_q == LAST_ROW) begin
                            row_cnt_q <= '0;
                            state_q   <= (gen_cnt_q != 8'd0) ? ST_RUN : ST_DRAIN;
                        end else begin
                            row_cnt_q <= row_cnt_q + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    grid_q    <= grid_next;
                    gen_cnt_q <= gen_cnt_q - 8'd1;
                    if (gen_cnt_q == 8'd1) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (out_fire) begin
                        if (row_cnt_q == LAST_ROW) begin
                            row_cnt_q <= '0;
                            state_q   <= ST_IDLE;
                            done_q    <= 1'b1;
                        end else begin
                            row_cnt_q <= row_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/grid_streamer.md
GRID_STREAMER -- requirements
Module: grid_streamer

Interface
REQ-001 Parameter: WIDTH, 8, cells per row.
REQ-002 Parameter: HEIGHT, 8, rows per grid; flattened grid is WIDTH*HEIGHT bits.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start  input  1  one-cycle request to begin a load/run/drain sequence.
REQ-007 step_count  input  8  number of generations to compute; sampled with start.
REQ-008 load_valid  input  1  load_data holds a valid row.
REQ-009 load_data  input  WIDTH  one grid row; bit WIDTH-1 is the leftmost cell.
REQ-010 load_ready  output  1  block accepts a row this cycle.
REQ-011 out_valid  output  1  out_data holds a valid result row.
REQ-012 out_data  output  WIDTH  one result row, same bit order as load_data.
REQ-013 out_ready  input  1  sink accepts out_data this cycle.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse after the last result row is accepted.

Function
REQ-016 States: IDLE, LOAD, RUN, DRAIN; encoding comes from the shared package.
REQ-017 Row order: row 0 is the top row, stored in flattened bits [WH-1 -: WIDTH]; row r occupies bits [WH-1-r*WIDTH -: WIDTH].
REQ-018 IDLE: start=1 latches step_count into the generation counter, clears the row counter, and moves to LOAD; start is ignored in any other state.
REQ-019 LOAD: load_ready=1; a row is written when load_valid&&load_ready; after the HEIGHT-th handshake the block moves to RUN if the counter is nonzero, else to DRAIN.
REQ-020 RUN: each cycle the grid register takes the next_state of the cell_grid instance and the counter decrements; when the counter reaches 1 in RUN, the block moves to DRAIN on the same edge.
REQ-021 Latency: with the last load handshake at edge t and K=step_count, the first out_valid is at cycle t+K+1 (K=0 gives t+1).
REQ-022 DRAIN: out_valid=1 and out_data=row[row counter]; the row counter advances only on out_valid&&out_ready; out_data holds stable under backpressure.
REQ-023 After the HEIGHT-th output handshake: transition to IDLE, done=1 for exactly that next cycle, and the grid register retains the final state.
REQ-024 Edges of the grid are dead; cells outside the grid are never considered alive.
REQ-025 load_ready=0 outside LOAD; out_valid=0 outside DRAIN; load_valid outside LOAD has no effect.
REQ-026 Row and generation counters saturate at no value; widths are $clog2(HEIGHT)+1 and 8 bits respectively, with no wrap-around reachable.

Reset
REQ-027 rst=1 immediately forces state IDLE, clears the grid register, counters, and done; load_ready, out_valid, busy, and done read 0.
REQ-028 Reset asserted mid-LOAD, mid-RUN, or mid-DRAIN aborts the sequence without a done pulse; the first start after release begins a fresh sequence.

Structure
REQ-029 A shared package grid_pkg holds the state enum and default WIDTH/HEIGHT constants.
REQ-030 Exactly one sub-module: the existing cell_grid, instantiated with #(WIDTH, HEIGHT) and fed from the grid register.
REQ-031 The block has no other combinational path from load_data to out_data.

Verification
REQ-032 Blinker: start with step_count=1, load rows 00,00,00,10,10,10,00,00 -> out rows 00,00,00,00,38,00,00,00, done pulses once.
REQ-033 Period-2 blinker: same load with step_count=2 -> output equals input; step_count=0 with beacon rows 00,60,60,18,18,00,00,00 -> identical rows returned, first out_valid one cycle after the last load.
REQ-034 Block still life 00,00,00,18,18,00,00,00 with step_count=5 -> unchanged rows; first out_valid exactly 6 cycles after the last load handshake.
REQ-035 Backpressure: toggle out_ready randomly in DRAIN -> each row is emitted once, in order, and held stable while stalled; load_valid gaps in LOAD only stall the sequence.
REQ-036 Robustness: a start pulse during RUN is ignored; rst asserted mid-RUN gives out_valid=0, busy=0, and no done pulse, and the next full sequence produces correct results.
